// File: rtl/cascade_key_loader.sv
// Streams one Cascade key (KEY_32_DEPTH 32-bit words) from the key BRAM into the correct-key register.
// Optional feature macro CASCADE_LOADER_PARITY_EN adds the per-word parity output word_parity.
module cascade_key_loader #(
  parameter int unsigned KEY_32_DEPTH = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned RD_LATENCY   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    key_rd_en,
  output logic [ADDR_WIDTH-1:0]   key_rd_addr,
  input  logic [31:0]             key_rd_data,
  output logic [31:0]             loading_key,
  output logic [KEY_32_DEPTH-1:0] loading_key_sel
`ifdef CASCADE_LOADER_PARITY_EN
  ,
  output logic [KEY_32_DEPTH-1:0] word_parity
`endif
);

  localparam int unsigned IDX_W = (KEY_32_DEPTH > 1) ? $clog2(KEY_32_DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_32_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                  state, state_d;
  logic                    busy_d, done_d, rd_en_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_d;
  logic [IDX_W-1:0]        rd_idx, rd_idx_d;
  logic [RD_LATENCY-1:0]   pipe_vld;
  logic [IDX_W-1:0]        pipe_idx [RD_LATENCY];
  logic                    cancel, strobe;
  logic [31:0]             key_d;
  logic [KEY_32_DEPTH-1:0] sel_d;

  // Next-state and next-output logic; abort overrides everything outside IDLE.
  always_comb begin
    state_d   = state;
    rd_en_d   = 1'b0;
    rd_addr_d = key_rd_addr;
    rd_idx_d  = rd_idx;
    done_d    = 1'b0;
    cancel    = abort && (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ISSUE;
          rd_en_d   = 1'b1;
          rd_addr_d = base_addr;
          rd_idx_d  = '0;
        end
      end
      S_ISSUE: begin
        if (rd_idx == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = key_rd_addr + ADDR_WIDTH'(1);
          rd_idx_d  = rd_idx + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        if (loading_key_sel[KEY_32_DEPTH-1]) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (cancel) begin
      state_d = S_IDLE;
      rd_en_d = 1'b0;
      done_d  = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
    strobe = pipe_vld[RD_LATENCY-1] && !cancel;
    key_d  = strobe ? key_rd_data : loading_key;
    sel_d  = strobe ? (KEY_32_DEPTH'(1) << pipe_idx[RD_LATENCY-1]) : '0;
  end

  // State, registered outputs and the read-tracking pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      key_rd_en       <= 1'b0;
      key_rd_addr     <= '0;
      rd_idx          <= '0;
      loading_key     <= '0;
      loading_key_sel <= '0;
      pipe_vld        <= '0;
      for (int i = 0; i < int'(RD_LATENCY); i++) pipe_idx[i] <= '0;
    end else begin
      state           <= state_d;
      busy            <= busy_d;
      done            <= done_d;
      key_rd_en       <= rd_en_d;
      key_rd_addr     <= rd_addr_d;
      rd_idx          <= rd_idx_d;
      loading_key     <= key_d;
      loading_key_sel <= sel_d;
      pipe_vld[0]     <= key_rd_en && !cancel;
      pipe_idx[0]     <= rd_idx;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        pipe_vld[i] <= pipe_vld[i-1] && !cancel;
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

`ifdef CASCADE_LOADER_PARITY_EN
  // Block parities for the first Cascade pass, captured alongside each word strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_parity <= '0;
    end else if ((state == S_IDLE) && start) begin
      word_parity <= '0;
    end else if (strobe) begin
      word_parity[pipe_idx[RD_LATENCY-1]] <= ^key_rd_data;
    end
  end
`endif

endmodule

// File: doc/cascade_key_loader.md
Name: cascade_key_loader

Overview:
Upstream feeder for the 32-bit-word Cascade correct-key register on Bob's post-processing path. On a start pulse, it reads KEY_32_DEPTH consecutive 32-bit sifted-key words from the key BRAM. It then presents each word on loading_key together with a one-hot loading_key_sel strobe, so the downstream register captures word k into slice [32k +: 32]. It signals done once the whole key is loaded, before the shuffle and inverse-shuffle passes begin.

Parameters:
KEY_32_DEPTH, 32, number of 32-bit words per Cascade key; key length = 32*KEY_32_DEPTH.
ADDR_WIDTH, 10, key BRAM word-address width.
RD_LATENCY, 1, BRAM read latency in cycles; legal values 1..4.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous reset, active-high.
start  in  1  single-cycle request to load one key; honoured only in IDLE.
abort  in  1  cancel an in-progress load.
base_addr  in  ADDR_WIDTH  BRAM word address of word 0; sampled on an accepted start.
busy  out  1  high while a load is in progress.
done  out  1  one-cycle pulse after the last word strobe.
key_rd_en  out  1  BRAM read enable.
key_rd_addr  out  ADDR_WIDTH  BRAM read address.
key_rd_data  in  32  BRAM read data, valid RD_LATENCY cycles after key_rd_en.
loading_key  out  32  word to load.
loading_key_sel  out  KEY_32_DEPTH  one-hot word strobe; bit k set means loading_key is word k.

Behaviour:
- Reset (rst=1 at posedge): the FSM enters IDLE. busy, done, key_rd_en, key_rd_addr, loading_key and loading_key_sel all become 0. All internal counters and pipeline valid bits are cleared. Reset takes priority over every other input, including mid-load; no done pulse is produced.
- FSM states:
  - IDLE: start=1 latches base_addr, clears the issue counter and moves to ISSUE.
  - ISSUE: asserts key_rd_en=1 on each of KEY_32_DEPTH consecutive cycles with key_rd_addr = base_addr + k, k = 0..KEY_32_DEPTH-1. The addition is modulo 2^ADDR_WIDTH (wraps, no error). After the last issue the FSM moves to DRAIN.
  - DRAIN: waits until the last word has been strobed, then moves to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Read pipeline: a RD_LATENCY-deep shift register carries the valid bit and word index alongside each read.
  - When the valid bit reaches the output, loading_key <= key_rd_data and loading_key_sel <= (1 << index) on the same edge.
  - Both hold for exactly one cycle. loading_key_sel is otherwise all-zero; loading_key holds its last value.
- Timing, with start accepted at edge T:
  - busy=1 from cycle T+1 through the DONE cycle inclusive.
  - First read at cycle T+1.
  - Word k strobed in cycle T+2+RD_LATENCY+k.
  - done in cycle T+2+RD_LATENCY+KEY_32_DEPTH.
  - busy drops the following cycle.
- Throughput: one word per cycle with no bubbles. Total load = KEY_32_DEPTH+RD_LATENCY+2 cycles from start to done.
- start while busy or in DONE: ignored, with no effect on the current load.
- start in the same cycle done falls: not accepted, because the FSM is still in DONE. Accepted from IDLE the next cycle.
- abort (any non-IDLE state):
  - Next edge: FSM to IDLE, key_rd_en=0, busy=0, pipeline valid bits cleared, loading_key_sel=0. No done pulse.
  - Words already strobed stay loaded downstream.
  - If start and abort are both high in IDLE, start wins. If both are high while busy, abort wins.
- The loader never drives loading_key_sel while the downstream shuffle is active; the sequencer guarantees mutual exclusion.

Optional Feature:
Macro CASCADE_LOADER_PARITY_EN.
- Defined:
  - Adds output word_parity [KEY_32_DEPTH-1:0].
  - On each word strobe, bit k <= XOR-reduce(key_rd_data). This gives the initial 32-bit block parities for the first Cascade pass without an extra pass.
  - Cleared to 0 on rst and on an accepted start; held after done.
- Undefined: the port and its logic are absent.

Test Plan:
All scenarios use KEY_32_DEPTH=4, RD_LATENCY=1, with a BRAM model holding mem[i]=32'hA5A50000+i.
- Basic load: start with base_addr=8 at T.
  - Required: key_rd_addr 8,9,10,11 in T+1..T+4.
  - Required: sel 0001/0010/0100/1000 with loading_key A5A50008..A5A5000B in T+3..T+6.
  - Required: done at T+7 and busy high for T+1..T+7.
- Address wrap: base_addr=10'h3FE.
  - Required: key_rd_addr 3FE, 3FF, 000, 001.
  - Required: word 2 = mem[0].
- Ignore start while busy: start re-pulsed at T+2 with base_addr=0.
  - Required: addresses unchanged, exactly one done.
- Abort mid-load: abort at T+3.
  - Required: busy=0 and sel=0 from T+4.
  - Required: at most word 0 strobed, no done.
  - Required: a new start at T+5 completes normally.
- Reset mid-load: rst at T+4.
  - Required: all outputs 0 next cycle, no done.
- RD_LATENCY=3: start at T.
  - Required: word 0 strobed at T+5, done at T+9.
- With CASCADE_LOADER_PARITY_EN: mem = {32'h1, 32'h3, 32'h7, 32'h0}.
  - Required: word_parity = 4'b0101 after done.
